// File: rtl/ld_driver_ramp_ctrl_if.sv
// rtl/ld_driver_ramp_ctrl_if.sv - control and status bundle of the LD current ramp controller
interface ld_driver_ramp_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             SW_ON;
  logic             LD_ON;
  logic             C_out;
  logic             Fault;
  logic [WIDTH-1:0] I_set;
  logic [WIDTH-1:0] I_out;
  logic [2:0]       state;
  logic             at_target;
  logic             busy;
  logic             fault_flag;

  modport master (
    output SW_ON, LD_ON, C_out, Fault, I_set,
    input  I_out, state, at_target, busy, fault_flag
  );

  modport slave (
    input  SW_ON, LD_ON, C_out, Fault, I_set,
    output I_out, state, at_target, busy, fault_flag
  );
endinterface

// File: rtl/ld_driver_ramp_ctrl.sv
// rtl/ld_driver_ramp_ctrl.sv - LD drive-current ramp FSM with setpoint tracking, clamp to I_MAX
// Optional latched fault shutdown enabled by defining LD_FAULT_LATCH_EN.
module ld_driver_ramp_ctrl #(
  parameter int WIDTH   = 12,
  parameter int I_MAX   = 2000,
  parameter int STEP_UP = 2,
  parameter int STEP_DN = 4
) (
  input logic               CLK,
  input logic               Clr,
  ld_driver_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD    = 3'd2,
    RAMP_DN = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] I_MAX_W = WIDTH'(I_MAX);
  localparam logic [WIDTH:0]   UP_W    = (WIDTH+1)'(STEP_UP);
  localparam logic [WIDTH:0]   DN_W    = (WIDTH+1)'(STEP_DN);

  state_t           state_q;
  logic             ld_on_q;
  logic [WIDTH-1:0] i_out_q;

  logic             on;
  logic             fault_go;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] floor_v;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_lim;

  assign tgt     = (bus.I_set > I_MAX_W) ? I_MAX_W : bus.I_set;
  assign on      = bus.SW_ON & ld_on_q;
  assign floor_v = on ? tgt : '0;

  // Both step results are computed one bit wide so the saturation compare sees the true value.
  assign up_sum = {1'b0, i_out_q} + UP_W;
  assign up_val = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[WIDTH-1:0];
  assign dn_lim = {1'b0, floor_v} + DN_W;
  assign dn_val = ({1'b0, i_out_q} <= dn_lim) ? floor_v : i_out_q - DN_W[WIDTH-1:0];

`ifdef LD_FAULT_LATCH_EN
  assign fault_go       = bus.Fault;
  assign bus.fault_flag = (state_q == FAULT);
`else
  logic unused_fault;
  assign unused_fault   = bus.Fault;
  assign fault_go       = 1'b0;
  assign bus.fault_flag = 1'b0;
`endif

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      state_q <= IDLE;
      ld_on_q <= 1'b0;
      i_out_q <= '0;
    end else begin
      ld_on_q <= bus.LD_ON;
      if (fault_go) begin
        state_q <= FAULT;
        i_out_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            i_out_q <= '0;
            if (on && (tgt != '0)) state_q <= RAMP_UP;
          end
          RAMP_UP: begin
            if (bus.C_out && (i_out_q < tgt)) i_out_q <= up_val;
            if (!on)                 state_q <= RAMP_DN;
            else if (i_out_q == tgt) state_q <= HOLD;
            else if (tgt < i_out_q)  state_q <= RAMP_DN;
          end
          HOLD: begin
            if (!on)                 state_q <= RAMP_DN;
            else if (tgt > i_out_q)  state_q <= RAMP_UP;
            else if (tgt < i_out_q)  state_q <= RAMP_DN;
          end
          RAMP_DN: begin
            // Stepping only while above the floor keeps a raised setpoint from snapping I_out upward.
            if (bus.C_out && (i_out_q > floor_v)) i_out_q <= dn_val;
            if (!on && (i_out_q == '0))     state_q <= IDLE;
            else if (on && (i_out_q == tgt)) state_q <= HOLD;
            else if (on && (tgt > i_out_q))  state_q <= RAMP_UP;
          end
          FAULT: begin
            i_out_q <= '0;
            if (!bus.SW_ON) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            i_out_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.I_out     = i_out_q;
  assign bus.state     = state_q;
  assign bus.at_target = (state_q == HOLD);
  assign bus.busy      = (state_q == RAMP_UP) || (state_q == RAMP_DN);

endmodule
